// File: rtl/cdda_serial_out.sv
// CDDA output stage: stereo PCM FIFO feeding a right-justified serialiser on DC_SCK/DC_SDAT/DC_LRCK.
// Optional build macro CDDA_UNDERRUN_CNT_EN adds the io_UNDERRUN_CNT saturating underrun counter.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | outputs parked low, counters held at 0, waiting for io_EN
// ST_RUN  | shifting frames; io_EN is re-examined at each frame boundary
module cdda_serial_out #(
    parameter int FIFO_DEPTH = 16,
    parameter int SCK_DIV    = 16,
    parameter int SLOT_BITS  = 24,
    parameter int LOW_WATER  = 4
) (
    input  logic                                io_CDCLK,
    input  logic                                io_RSTn,
    input  logic                                io_EN,
    input  logic                                io_EMPH_IN,
    input  logic                                io_FLUSH,
    input  logic                                io_PCM_VALID,
    input  logic [31:0]                         io_PCM_DATA,
    output logic                                io_PCM_READY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     io_FIFO_LEVEL,
    output logic                                io_LOW_WATER,
    output logic                                io_DC_SCK,
    output logic                                io_DC_SDAT,
    output logic                                io_DC_LRCK,
    output logic                                io_DC_EMPH
`ifdef CDDA_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                         io_UNDERRUN_CNT
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int DW  = $clog2(SCK_DIV);
    localparam int BW  = $clog2(SLOT_BITS);
    localparam int PAD = SLOT_BITS - 16;

    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_LOW  = LW'(LOW_WATER);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(SCK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_BITS - 1);
    localparam logic [BW-1:0] BIT_PAD  = BW'(PAD);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic [DW-1:0]   div_cnt, div_inc;
    logic [BW-1:0]   bit_cnt, bit_nxt;
    logic            slot, slot_nxt, bit_wrap;
    logic [31:0]     shreg, load_val;
    logic            sck_q, sdat_q, lrck_q, emph_q;
    logic            full, empty, push, pop;
    logic            frame_end, frame_start;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign push  = io_PCM_VALID && !full;
    assign pop   = frame_start && !empty;

    assign frame_end = (state_q == ST_RUN) && (div_cnt == DIV_LAST) &&
                       (bit_cnt == BIT_LAST) && slot;

    always_ff @(posedge io_CDCLK) begin
        if (!io_RSTn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame starts on the edge that moves the counters to slot 0 / bit 0 / div 0,
    // so the popped word is already in the shift register for the first bit.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_EN) begin
                    state_d     = ST_RUN;
                    frame_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_end) begin
                    if (io_EN) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge io_CDCLK) begin
        if (!io_RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (io_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge io_CDCLK) begin
        if (io_RSTn && push && !io_FLUSH) begin
            mem[wr_ptr] <= io_PCM_DATA;
        end
    end

    assign load_val = pop ? mem[rd_ptr] : 32'h0;
    assign div_inc  = div_cnt + 1'b1;
    assign bit_wrap = (bit_cnt == BIT_LAST);
    assign bit_nxt  = bit_wrap ? '0 : bit_cnt + 1'b1;
    assign slot_nxt = slot ^ bit_wrap;

    // Left sample occupies shreg[31:16] and right [15:0], so one left shift per
    // sample bit walks through both channels in output order.
    always_ff @(posedge io_CDCLK) begin
        if (!io_RSTn) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            slot    <= 1'b0;
            shreg   <= '0;
            sck_q   <= 1'b0;
            sdat_q  <= 1'b0;
            lrck_q  <= 1'b0;
        end else if (state_d == ST_IDLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            slot    <= 1'b0;
            sck_q   <= 1'b0;
            sdat_q  <= 1'b0;
            lrck_q  <= 1'b0;
        end else if (frame_start) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            slot    <= 1'b0;
            sck_q   <= 1'b0;
            lrck_q  <= 1'b0;
            if (PAD == 0) begin
                sdat_q <= load_val[31];
                shreg  <= {load_val[30:0], 1'b0};
            end else begin
                sdat_q <= 1'b0;
                shreg  <= load_val;
            end
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck_q   <= 1'b0;
            bit_cnt <= bit_nxt;
            slot    <= slot_nxt;
            lrck_q  <= slot_nxt;
            if (bit_nxt >= BIT_PAD) begin
                sdat_q <= shreg[31];
                shreg  <= {shreg[30:0], 1'b0};
            end else begin
                sdat_q <= 1'b0;
            end
        end else begin
            div_cnt <= div_inc;
            sck_q   <= (div_inc >= DIV_HALF);
        end
    end

    always_ff @(posedge io_CDCLK) begin
        if (!io_RSTn) begin
            emph_q <= 1'b0;
        end else begin
            emph_q <= io_EMPH_IN;
        end
    end

`ifdef CDDA_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
    logic        underrun;

    assign underrun = frame_start && empty;

    always_ff @(posedge io_CDCLK) begin
        if (!io_RSTn) begin
            underrun_cnt <= '0;
        end else if (io_FLUSH) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

    assign io_UNDERRUN_CNT = underrun_cnt;
`endif

    assign io_PCM_READY  = !full;
    assign io_FIFO_LEVEL = level;
    assign io_LOW_WATER  = (level <= LVL_LOW);
    assign io_DC_SCK     = sck_q;
    assign io_DC_SDAT    = sdat_q;
    assign io_DC_LRCK    = lrck_q;
    assign io_DC_EMPH    = emph_q;

endmodule

// File: tb/tb_cdda_serial_out.sv
// Bench for cdda_serial_out: frame-level reference model compared every cycle, plus literal spot checks.
// Build with CDDA_UNDERRUN_CNT_EN defined to also cover the underrun counter.
module tb_cdda_serial_out;

    localparam int DEPTH = 16;
    localparam int FRAME = 768;

    logic        clk = 1'b0;
    logic        rstn, en, emph_in, flush, valid;
    logic [31:0] data;
    logic        ready, low, sck, sdat, lrck, emph;
    logic [4:0]  level;
`ifdef CDDA_UNDERRUN_CNT_EN
    logic [15:0] ucnt;
`endif

    always #5 clk = ~clk;

    cdda_serial_out dut (
        .io_CDCLK      (clk),
        .io_RSTn       (rstn),
        .io_EN         (en),
        .io_EMPH_IN    (emph_in),
        .io_FLUSH      (flush),
        .io_PCM_VALID  (valid),
        .io_PCM_DATA   (data),
        .io_PCM_READY  (ready),
        .io_FIFO_LEVEL (level),
        .io_LOW_WATER  (low),
        .io_DC_SCK     (sck),
        .io_DC_SDAT    (sdat),
        .io_DC_LRCK    (lrck),
        .io_DC_EMPH    (emph)
`ifdef CDDA_UNDERRUN_CNT_EN
        ,
        .io_UNDERRUN_CNT (ucnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a frame queue plus a phase counter within the current 768-cycle frame.
    logic [31:0] m_q[$];
    logic [31:0] m_cur;
    logic        m_run, m_emph, m_push, m_start, m_stop;
    int          m_k, m_uf;

    always @(posedge clk) begin
        if (!rstn) begin
            m_q.delete();
            m_cur  = '0;
            m_run  = 1'b0;
            m_k    = 0;
            m_uf   = 0;
            m_emph = 1'b0;
        end else begin
            m_push  = valid && (m_q.size() < DEPTH);
            m_start = en && (!m_run || m_k == FRAME - 1);
            m_stop  = m_run && (m_k == FRAME - 1) && !en;
            if (m_start) begin
                if (m_q.size() > 0) m_cur = m_q.pop_front();
                else begin
                    m_cur = '0;
                    if (m_uf < 65535) m_uf++;
                end
            end
            if (m_push) m_q.push_back(data);
            if (flush) begin
                m_q.delete();
                m_uf = 0;
            end
            if (m_start) begin
                m_run = 1'b1;
                m_k   = 0;
            end else if (m_stop) begin
                m_run = 1'b0;
                m_k   = 0;
            end else if (m_run) begin
                m_k++;
            end
            m_emph = emph_in;
        end
    end

    // {sck, lrck, sdat} at phase k of a frame carrying word f.
    function automatic logic [2:0] exp_serial(input int k, input logic [31:0] f);
        int bitpos, sl, b;
        logic s;
        bitpos = k / 16;
        sl     = bitpos / 24;
        b      = bitpos % 24;
        s      = (b < 8) ? 1'b0 : f[(sl == 1 ? 15 : 31) - (b - 8)];
        return {((k % 16) >= 8), (sl == 1), s};
    endfunction

    logic       cmp_en = 1'b0;
    logic [2:0] m_ser;

    always @(negedge clk) begin
        if (cmp_en) begin
            m_ser = m_run ? exp_serial(m_k, m_cur) : 3'b000;
            check("level", level, m_q.size());
            check("ready", ready, m_q.size() < DEPTH);
            check("low_water", low, m_q.size() <= 4);
            check("emph", emph, m_emph);
            check("sck", sck, m_ser[2]);
            check("lrck", lrck, m_ser[1]);
            check("sdat", sdat, m_ser[0]);
`ifdef CDDA_UNDERRUN_CNT_EN
            check("underrun_cnt", ucnt, m_uf);
`endif
        end
    end

    // Observer of the serial pins, independent of the model.
    logic [47:0] cap;
    int          n_rise, n_ones, n_unstable, n_lr, lr_iv, lr_last, cyc;
    logic        sck_p = 1'b0, sdat_p = 1'b0, lrck_p = 1'b0;

    always @(negedge clk) begin
        if (sck && !sck_p) begin
            cap = {cap[46:0], sdat};
            n_rise++;
            if (sdat) n_ones++;
        end
        if (sck && (sdat !== sdat_p)) n_unstable++;
        if (lrck !== lrck_p) begin
            n_lr++;
            lr_iv   = cyc - lr_last;
            lr_last = cyc;
        end
        sck_p  = sck;
        sdat_p = sdat;
        lrck_p = lrck;
        cyc++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_obs();
        cap        = '0;
        n_rise     = 0;
        n_ones     = 0;
        n_unstable = 0;
        n_lr       = 0;
        lr_iv      = 0;
        lr_last    = cyc;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; emph_in = 1'b0; flush = 1'b0; valid = 1'b0; data = '0;
        cyc = 0;
        clr_obs();
        tick();
        cmp_en = 1'b1;
        repeat (19) tick();
        check("rst_level", level, 5'd0);
        check("rst_ready", ready, 1'b1);
        check("rst_low", low, 1'b1);
        check("rst_pins", {sck, sdat, lrck, emph}, 4'b0000);
        rstn = 1'b1;

        // Single known frame, then stop exactly at its end.
        tick();
        valid = 1'b1; data = 32'h8001_7FFE; emph_in = 1'b1;
        tick();
        valid = 1'b0; en = 1'b1;
        check("emph_follow", emph, 1'b1);
        clr_obs();
        repeat (FRAME) tick();
        en = 1'b0;
        repeat (5) tick();
        check("frame_bits", cap, 48'h0080_0100_7FFE);
        check("frame_rises", n_rise, 48);
        check("lrck_period", lr_iv, 384);
        check("sdat_stable", n_unstable, 0);
        check("idle_sck", sck, 1'b0);

        // Three underrun frames.
        flush = 1'b1; emph_in = 1'b0;
        tick();
        flush = 1'b0; en = 1'b1;
        clr_obs();
        repeat (2 * FRAME + 100) tick();
        en = 1'b0;
        repeat (800) tick();
        check("mute_ones", n_ones, 0);
        check("mute_rises", n_rise, 144);
        check("mute_lrck_toggles", n_lr, 6);
`ifdef CDDA_UNDERRUN_CNT_EN
        check("underrun_3", ucnt, 16'd3);
`endif

        // Fill to full with VALID held, one extra offer, then a single pop.
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 16) begin
                check("full_level", level, 5'd16);
                check("full_ready", ready, 1'b0);
            end
            valid = 1'b1;
            data  = 32'h1234_5678 ^ (i * 32'h0F0F_1111);
        end
        tick();
        valid = 1'b0;
        check("overfill_level", level, 5'd16);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("pop_level", level, 5'd15);
        check("pop_ready", ready, 1'b1);
        repeat (800) tick();

        // Drop EN mid-left slot, then restart.
        en = 1'b1;
        repeat (200) tick();
        en = 1'b0;
        repeat (700) tick();
        check("stop_pins", {sck, sdat, lrck}, 3'b000);
        check("stop_level", level, 5'd14);
        en = 1'b1; emph_in = 1'b1;
        tick();
        check("restart_level", level, 5'd13);
        repeat (400) tick();
        en = 1'b0;
        repeat (500) tick();

        // FLUSH colliding with a push at level 5 while a frame is in flight.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle_level", level, 5'd0);
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1;
            data  = 32'hC3A5_0000 + 32'(i * 32'h0001_0203);
            tick();
        end
        valid = 1'b0; en = 1'b1;
        tick();
        check("pre_flush_level", level, 5'd5);
        repeat (50) tick();
        flush = 1'b1; valid = 1'b1; data = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; valid = 1'b0;
        check("flush_level", level, 5'd0);
        repeat (FRAME) tick();
        en = 1'b0;
        repeat (800) tick();
`ifdef CDDA_UNDERRUN_CNT_EN
        check("underrun_after_flush", ucnt, 16'd1);
`endif
        check("end_level", level, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
